// File: rtl/tow_round_arbiter.sv
// Multi-player tug-of-war round arbiter.
// Synchronizes and debounces N push-buttons, awards each round to the first
// debounced press (or flags a tie when several land together), keeps a
// saturating score per player and stops the game at WIN_SCORE.
module tow_round_arbiter #(
   parameter  int N_PLAYERS = 2,
   parameter  int DB_CYCLES = 4,
   parameter  int SCORE_W   = 4,
   parameter  int WIN_SCORE = 7,
   localparam int ID_W      = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic [N_PLAYERS-1:0]         pb,
   output logic                         winrnd,
   output logic [ID_W-1:0]              winner,
   output logic                         tie,
   output logic [N_PLAYERS*SCORE_W-1:0] scores,
   output logic                         game_over,
   output logic                         armed
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RESULT,
      S_GAMEOVER
   } state_t;

   logic [N_PLAYERS-1:0]         r_sync1;
   logic [N_PLAYERS-1:0]         r_sync2;
   logic [N_PLAYERS-1:0]         r_db;
   logic [N_PLAYERS-1:0]         r_db_d;
   logic [CNT_W-1:0]             r_cnt [N_PLAYERS];

   state_t                       r_state;
   logic                         r_winrnd;
   logic [ID_W-1:0]              r_winner;
   logic                         r_tie;
   logic [N_PLAYERS*SCORE_W-1:0] r_scores;
   logic                         r_game_over;

   logic [N_PLAYERS-1:0]         w_press;
   logic                         w_one;
   logic                         w_multi;
   logic [ID_W-1:0]              w_idx;
   logic [SCORE_W-1:0]           w_cur;
   logic [SCORE_W-1:0]           w_inc;

   state_t                       w_state_nx;
   logic                         w_winrnd_nx;
   logic [ID_W-1:0]              w_winner_nx;
   logic                         w_tie_nx;
   logic [N_PLAYERS*SCORE_W-1:0] w_scores_nx;
   logic                         w_game_over_nx;

   // Two-flop synchronizer plus the debounced-level delay used for edge detect.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db_d  <= '0;
      end else begin
         r_sync1 <= pb;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
      end
   end

   // Debouncer: accept a new level after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_db <= '0;
         for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (r_sync2[i] != r_db[i]) begin
               if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                  r_db[i]  <= r_sync2[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 1'b1;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // Press pulses, single/multiple press classification and the scoring increment.
   always_comb begin
      w_press = r_db & ~r_db_d;
      w_multi = (w_press & (w_press - N_PLAYERS'(1))) != '0;
      w_one   = (w_press != '0) && !w_multi;
      w_idx   = '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
         if (w_press[i]) begin
            w_idx = ID_W'(i);
         end
      end
      w_cur = r_scores[w_idx*SCORE_W +: SCORE_W];
      w_inc = (w_cur < SCORE_W'(WIN_SCORE)) ? w_cur + 1'b1 : w_cur;
   end

   // Round FSM next-state and registered-output logic; clr has priority in ARMED.
   always_comb begin
      w_state_nx     = r_state;
      w_winrnd_nx    = r_winrnd;
      w_winner_nx    = r_winner;
      w_tie_nx       = r_tie;
      w_scores_nx    = r_scores;
      w_game_over_nx = r_game_over;
      case (r_state)
         S_IDLE: begin
            if (clr) begin
               w_state_nx = S_ARMED;
            end
         end
         S_ARMED: begin
            if (!clr) begin
               if (w_one) begin
                  w_winrnd_nx = 1'b1;
                  w_winner_nx = w_idx;
                  w_scores_nx[w_idx*SCORE_W +: SCORE_W] = w_inc;
                  if (w_inc == SCORE_W'(WIN_SCORE)) begin
                     w_game_over_nx = 1'b1;
                     w_state_nx     = S_GAMEOVER;
                  end else begin
                     w_state_nx = S_RESULT;
                  end
               end else if (w_multi) begin
                  w_tie_nx   = 1'b1;
                  w_state_nx = S_RESULT;
               end
            end
         end
         S_RESULT: begin
            if (clr) begin
               w_winrnd_nx = 1'b0;
               w_winner_nx = '0;
               w_tie_nx    = 1'b0;
               w_state_nx  = S_ARMED;
            end
         end
         S_GAMEOVER: begin
            if (clr) begin
               w_winrnd_nx    = 1'b0;
               w_winner_nx    = '0;
               w_tie_nx       = 1'b0;
               w_scores_nx    = '0;
               w_game_over_nx = 1'b0;
               w_state_nx     = S_ARMED;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Round FSM state and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_winrnd    <= 1'b0;
         r_winner    <= '0;
         r_tie       <= 1'b0;
         r_scores    <= '0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_winrnd    <= w_winrnd_nx;
         r_winner    <= w_winner_nx;
         r_tie       <= w_tie_nx;
         r_scores    <= w_scores_nx;
         r_game_over <= w_game_over_nx;
      end
   end

   assign winrnd    = r_winrnd;
   assign winner    = r_winner;
   assign tie       = r_tie;
   assign scores    = r_scores;
   assign game_over = r_game_over;
   assign armed     = (r_state == S_ARMED);

endmodule
